tls_intersection_ctrl: RTL and testbench

//  Sequences a two-approach intersection: approach A and approach B, plus a pedestrian

---
 rtl/tls_pkg.sv | 29 ++
 rtl/tls_phase_timer.sv | 33 +++
 rtl/tls_intersection_ctrl.sv | 141 ++++++++++++++
 tb/tb_tls_intersection_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tls_pkg.sv
// Shared definitions for the two-approach intersection controller:
// state encoding, default field width and the {G,Y,R} lamp vectors.
package tls_pkg;

    localparam int TW_DEF = 4;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_A_GRN  = 3'd1,
        ST_A_YEL  = 3'd2,
        ST_CLR_AB = 3'd3,
        ST_B_GRN  = 3'd4,
        ST_B_YEL  = 3'd5,
        ST_CLR_BA = 3'd6,
        ST_WALK   = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    // Lamp decode for one approach, given which states are its green/yellow.
    function automatic logic [2:0] lamp_of(state_t s, state_t grn, state_t yel);
        if (s == grn)      return LAMP_G;
        else if (s == yel) return LAMP_Y;
        else               return LAMP_R;
    endfunction

endpackage

// File: rtl/tls_phase_timer.sv
// Phase counter for the intersection controller.
//   clk, rst : clock, async active-high reset (cnt -> 1)
//   load     : restart the phase, cnt -> 1 (wins over hold)
//   hold     : freeze cnt
//   tmax     : phase length in cycles, 0 behaves as 1
//   done     : cnt has reached the phase length
module tls_phase_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          hold,
    input  logic [TW-1:0] tmax,
    output logic          done
);

    logic [TW-1:0] cnt;
    logic [TW-1:0] lim;

    assign lim  = (tmax == '0) ? TW'(1) : tmax;
    assign done = (cnt >= lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= TW'(1);
        else if (load)
            cnt <= TW'(1);
        else if (!hold && cnt != '1)
            cnt <= cnt + TW'(1);
    end

endmodule

// File: rtl/tls_intersection_ctrl.sv
// Two-approach intersection sequencer with all-red clearance, a latched
// pedestrian walk phase after approach B, and emergency preemption.
//   clk, reset          : clock, async active-high reset
//   Set                 : load Gin/Yin/Cin and restart from INIT
//   Stop                : freeze state and phase counter (emg still acts)
//   Gin/Yin/Cin         : green / yellow / clearance lengths in cycles
//   ped_req             : pedestrian request (pulse or level)
//   emg, emg_dir        : preemption request and target approach (0=A, 1=B)
//   A_G..B_R, walk      : lamp outputs, decoded from registered state
//   ped_ack             : one-cycle pulse in the first WALK cycle
//   busy_emg            : emergency sequence in progress
module tls_intersection_ctrl
    import tls_pkg::*;
#(
    parameter int TW        = TW_DEF,
    parameter int WALK_TIME = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Set,
    input  logic          Stop,
    input  logic [TW-1:0] Gin,
    input  logic [TW-1:0] Yin,
    input  logic [TW-1:0] Cin,
    input  logic          ped_req,
    input  logic          emg,
    input  logic          emg_dir,
    output logic          A_G,
    output logic          A_Y,
    output logic          A_R,
    output logic          B_G,
    output logic          B_Y,
    output logic          B_R,
    output logic          walk,
    output logic          ped_ack,
    output logic          busy_emg
);

    localparam logic [TW-1:0] WALK_T = TW'(WALK_TIME);

    state_t        state, nxt, x_grn;
    logic [TW-1:0] g_t, y_t, c_t, tmax;
    logic          ped_pend, emg_act, emg_tgt;
    logic          tgt, eff, fire, freeze, load, done;

    tls_phase_timer #(.TW(TW)) u_timer (
        .clk  (clk),
        .rst  (reset),
        .load (load),
        .hold (Stop),
        .tmax (tmax),
        .done (done)
    );

    always_comb begin
        tmax = TW'(1);
        case (state)
            ST_A_GRN, ST_B_GRN:   tmax = g_t;
            ST_A_YEL, ST_B_YEL:   tmax = y_t;
            ST_CLR_AB, ST_CLR_BA: tmax = c_t;
            ST_WALK:              tmax = WALK_T;
            default:              tmax = TW'(1);
        endcase
    end

    // A live request overrides the latched target; the latch keeps the
    // sequence heading to the target green even if emg drops early.
    always_comb begin
        tgt    = emg ? emg_dir : emg_tgt;
        eff    = emg | emg_act;
        x_grn  = tgt ? ST_B_GRN : ST_A_GRN;
        fire   = !Stop && done;
        nxt    = state;
        freeze = 1'b0;
        if (Set) begin
            nxt = ST_INIT;
        end else begin
            case (state)
                ST_INIT:   nxt = ST_A_GRN;
                ST_A_GRN: begin
                    if (eff && tgt)       nxt = ST_A_YEL;
                    else if (emg && !tgt) freeze = 1'b1;
                    else if (fire)        nxt = ST_A_YEL;
                end
                ST_A_YEL:  if (fire) nxt = ST_CLR_AB;
                ST_CLR_AB: if (fire) nxt = eff ? x_grn : ST_B_GRN;
                ST_B_GRN: begin
                    if (eff && !tgt)     nxt = ST_B_YEL;
                    else if (emg && tgt) freeze = 1'b1;
                    else if (fire)       nxt = ST_B_YEL;
                end
                ST_B_YEL:  if (fire) nxt = ST_CLR_BA;
                ST_CLR_BA: if (fire) nxt = eff ? x_grn : (ped_pend ? ST_WALK : ST_A_GRN);
                ST_WALK: begin
                    if (eff)       nxt = ST_CLR_BA;
                    else if (fire) nxt = ST_A_GRN;
                end
                default:   nxt = ST_INIT;
            endcase
        end
        load = Set | freeze | (nxt != state);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_INIT;
        else       state <= nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_t      <= '0;
            y_t      <= '0;
            c_t      <= '0;
            ped_pend <= 1'b0;
            ped_ack  <= 1'b0;
            emg_act  <= 1'b0;
            emg_tgt  <= 1'b0;
        end else begin
            if (Set) begin
                g_t <= Gin;
                y_t <= Yin;
                c_t <= Cin;
            end
            ped_ack  <= (nxt == ST_WALK) && (state != ST_WALK);
            ped_pend <= ((nxt == ST_WALK) && (state != ST_WALK)) ? 1'b0 : (ped_pend | ped_req);
            if (Set)
                emg_act <= 1'b0;
            else if (emg) begin
                emg_act <= 1'b1;
                emg_tgt <= emg_dir;
            end else if (state == x_grn)
                emg_act <= 1'b0;  // target green now runs normal timing
        end
    end

    assign {A_G, A_Y, A_R} = lamp_of(state, ST_A_GRN, ST_A_YEL);
    assign {B_G, B_Y, B_R} = lamp_of(state, ST_B_GRN, ST_B_YEL);
    assign walk     = (state == ST_WALK);
    assign busy_emg = !reset && (emg || (emg_act && state != x_grn));

endmodule

// File: tb/tb_tls_intersection_ctrl.sv
module tb_tls_intersection_ctrl;

    localparam int TW = 4;
    localparam int WT = 6;

    logic clk = 1'b0;
    logic reset, Set, Stop, ped_req, emg, emg_dir;
    logic [TW-1:0] Gin, Yin, Cin;
    logic A_G, A_Y, A_R, B_G, B_Y, B_R, walk, ped_ack, busy_emg;

    tls_intersection_ctrl #(.TW(TW), .WALK_TIME(WT)) dut (
        .clk(clk), .reset(reset), .Set(Set), .Stop(Stop),
        .Gin(Gin), .Yin(Yin), .Cin(Cin), .ped_req(ped_req),
        .emg(emg), .emg_dir(emg_dir),
        .A_G(A_G), .A_Y(A_Y), .A_R(A_R), .B_G(B_G), .B_Y(B_Y), .B_R(B_R),
        .walk(walk), .ped_ack(ped_ack), .busy_emg(busy_emg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_ag, n_bg, n_by, n_walk, n_ack;

    // Reference model: phase ring 0..5 = A green, A yellow, clear, B green,
    // B yellow, clear; 6 = walk; 7 = init. age counts cycles in the phase.
    int m_ph, m_age, m_g, m_y, m_c;
    bit m_pend, m_ack, m_eact, m_etgt;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int phase_len(int ph);
        int t;
        case (ph)
            0, 3:    t = m_g;
            1, 4:    t = m_y;
            2, 5:    t = m_c;
            6:       t = WT;
            default: t = 1;
        endcase
        return (t == 0) ? 1 : t;
    endfunction

    function automatic logic [8:0] exp_out();
        logic [2:0] a, b;
        logic bz;
        a  = (m_ph == 0) ? 3'b100 : (m_ph == 1) ? 3'b010 : 3'b001;
        b  = (m_ph == 3) ? 3'b100 : (m_ph == 4) ? 3'b010 : 3'b001;
        bz = !reset && (emg || (m_eact && m_ph != (m_etgt ? 3 : 0)));
        return {a, b, m_ph == 6, m_ack, bz};
    endfunction

    task automatic model_reset();
        m_ph = 7; m_age = 1; m_g = 0; m_y = 0; m_c = 0;
        m_pend = 0; m_ack = 0; m_eact = 0; m_etgt = 0;
    endtask

    task automatic model_step();
        int nph, xg;
        bit eff, tgt, frz, tdone;
        if (reset) begin
            model_reset();
            return;
        end
        if (Set) begin
            m_g = Gin; m_y = Yin; m_c = Cin;
            m_ph = 7; m_age = 1; m_ack = 0; m_eact = 0;
            m_pend = m_pend | ped_req;
            return;
        end
        eff   = emg || m_eact;
        tgt   = emg ? emg_dir : m_etgt;
        xg    = tgt ? 3 : 0;
        tdone = !Stop && (m_age >= phase_len(m_ph));
        nph   = m_ph;
        frz   = 0;
        case (m_ph)
            7: nph = 0;
            6: if (eff) nph = 5; else if (tdone) nph = 0;
            0, 3: begin
                if (eff && m_ph != xg)       nph = m_ph + 1;
                else if (emg && m_ph == xg)  frz = 1;
                else if (tdone)              nph = m_ph + 1;
            end
            1, 4: if (tdone) nph = m_ph + 1;
            2:    if (tdone) nph = eff ? xg : 3;
            default: if (tdone) nph = eff ? xg : (m_pend ? 6 : 0);
        endcase
        m_ack  = (nph == 6) && (m_ph != 6);
        m_pend = m_ack ? 1'b0 : (m_pend | ped_req);
        if (emg) begin
            m_eact = 1; m_etgt = emg_dir;
        end else if (m_ph == (m_etgt ? 3 : 0)) begin
            m_eact = 0;
        end
        if (nph != m_ph || frz) m_age = 1;
        else if (!Stop && m_age < 15) m_age++;
        m_ph = nph;
    endtask

    function automatic logic [8:0] dut_out();
        return {A_G, A_Y, A_R, B_G, B_Y, B_R, walk, ped_ack, busy_emg};
    endfunction

    task automatic tick();
        @(negedge clk);
        chk("outputs", int'(dut_out()), int'(exp_out()));
        chk("one_lamp_per_approach", $countones({A_G, A_Y, A_R}) + $countones({B_G, B_Y, B_R}), 2);
        chk("never_both_nonred", int'(A_R | B_R), 1);
        n_ag += A_G; n_bg += B_G; n_by += B_Y; n_walk += walk; n_ack += ped_ack;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr_tally();
        n_ag = 0; n_bg = 0; n_by = 0; n_walk = 0; n_ack = 0;
    endtask

    task automatic wait_ph(input int ph, input int age);
        int n = 0;
        while (!(m_ph == ph && (age == 0 || m_age == age)) && n < 300) begin
            tick();
            n++;
        end
        chk("wait_phase_reached", int'(n < 300), 1);
    endtask

    initial begin
        reset = 1; Set = 0; Stop = 0; ped_req = 0; emg = 0; emg_dir = 0;
        Gin = 0; Yin = 0; Cin = 0;
        model_reset();
        clr_tally();
        #2;
        chk("reset_state", int'(dut_out()), int'(9'b001_001_000));
        tick(); tick();
        reset = 0;

        // 1: plain cycle, period 12
        Gin = 3; Yin = 2; Cin = 1; Set = 1; tick(); Set = 0;
        tick();
        clr_tally();
        repeat (24) tick();
        chk("t1_a_green_cycles", n_ag, 6);
        chk("t1_b_yellow_cycles", n_by, 4);

        // 2: pedestrian pulse in A green
        wait_ph(0, 1);
        ped_req = 1; tick(); ped_req = 0;
        clr_tally();
        repeat (29) tick();
        chk("t2_walk_cycles", n_walk, 6);
        chk("t2_ack_pulses", n_ack, 1);

        // 3: emergency toward B from A green
        wait_ph(0, 1);
        emg = 1; emg_dir = 1;
        clr_tally();
        repeat (24) tick();
        chk("t3_b_green_held", n_bg, 20);
        emg = 0;
        clr_tally();
        repeat (5) tick();
        chk("t3_b_green_after_release", n_bg, 3);

        // 4: Stop for 5 cycles in B yellow, ped request during Stop
        wait_ph(4, 1);
        clr_tally();
        tick();
        Stop = 1; ped_req = 1; tick(); ped_req = 0;
        repeat (4) tick();
        Stop = 0;
        repeat (4) tick();
        chk("t4_b_yellow_stretched", n_by, 7);
        repeat (10) tick();
        chk("t4_walk_served", n_walk, 6);

        // 5: Set with Gin=0 during clearance
        wait_ph(2, 0);
        Gin = 0; Set = 1; tick(); Set = 0;
        clr_tally();
        repeat (3) tick();
        chk("t5_a_green_one_cycle", n_ag, 1);

        // 6: reset during WALK
        ped_req = 1; tick(); ped_req = 0;
        wait_ph(6, 3);
        reset = 1;
        model_reset();
        #1;
        chk("t6_reset_mid_walk", int'(dut_out()), int'(9'b001_001_000));
        tick(); tick();
        reset = 0;
        Gin = 3; Yin = 2; Cin = 1; Set = 1; tick(); Set = 0;
        clr_tally();
        repeat (20) tick();
        chk("t6_ped_pend_cleared", n_walk, 0);

        // randomized traffic
        repeat (3000) begin
            reset   = ($urandom_range(0, 299) == 0);
            if (reset) model_reset();
            Set     = ($urandom_range(0, 99) == 0);
            if (Set) begin
                Gin = 4'($urandom_range(0, 5));
                Yin = 4'($urandom_range(0, 3));
                Cin = 4'($urandom_range(0, 3));
            end
            Stop    = ($urandom_range(0, 19) == 0);
            ped_req = ($urandom_range(0, 9) == 0);
            if (!emg && $urandom_range(0, 79) == 0) begin
                emg = 1; emg_dir = 1'($urandom);
            end else if (emg && $urandom_range(0, 29) == 0) begin
                emg = 0;
            end
            if (emg && $urandom_range(0, 49) == 0) emg_dir = ~emg_dir;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
